// File: rtl/sdq_queue_ctrl.sv
// sdq_queue_ctrl
// Valid/ready FIFO wrapper around the single-clock sdq_17x64 SRAM macro.
// Entries are written straight into the array. They are prefetched through the
// macro's 1-cycle read port into a 2-entry output buffer. When the buffer is
// empty and a read is returning, the returning word is presented directly on
// deq_data, which keeps the enqueue-to-dequeue latency at two cycles and
// sustains one word per cycle in steady state.
module sdq_queue_ctrl #(
    parameter int DEPTH = 17,
    parameter int WIDTH = 64,
    parameter int AW    = 5,
    parameter int CW    = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_data,
    output logic [CW-1:0]    count,
    output logic             mem_W0_en,
    output logic [AW-1:0]    mem_W0_addr,
    output logic [WIDTH-1:0] mem_W0_data,
    output logic             mem_R0_en,
    output logic [AW-1:0]    mem_R0_addr,
    input  logic [WIDTH-1:0] mem_R0_data
);

    // Total capacity: the full array plus the two output-buffer slots.
    localparam logic [CW-1:0] CAP_C      = CW'(DEPTH + 2);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] LAST_PTR_C = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE_C  = {{(AW-1){1'b0}}, 1'b1};

    // Pointer advance with wrap at the last array entry (DEPTH need not be 2**AW).
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        logic [AW-1:0] nxt;
        if (ptr == LAST_PTR_C) begin
            nxt = {AW{1'b0}};
        end else begin
            nxt = ptr + PTR_ONE_C;
        end
        return nxt;
    endfunction

    // State registers
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
    logic             rd_inflight_q, rd_inflight_d;
    logic [1:0]       obuf_cnt_q, obuf_cnt_d;
    logic [WIDTH-1:0] obuf0_q, obuf0_d;
    logic [WIDTH-1:0] obuf1_q, obuf1_d;
    logic [CW-1:0]    count_q, count_d;

    // Combinational control
    logic       enq_ready_s;
    logic       deq_valid_s;
    logic       enq_fire_s;
    logic       deq_fire_s;
    logic [2:0] occ_s;
    logic       rd_issue_s;
    logic       bypass_s;
    logic       obuf_push_s;
    logic       obuf_pop_s;

    // Handshakes, read-issue decision and output-buffer push/pop strobes.
    always_comb begin
        enq_ready_s = 1'b0;
        deq_valid_s = 1'b0;
        enq_fire_s  = 1'b0;
        deq_fire_s  = 1'b0;
        occ_s       = 3'd0;
        rd_issue_s  = 1'b0;
        bypass_s    = 1'b0;
        obuf_push_s = 1'b0;
        obuf_pop_s  = 1'b0;

        enq_ready_s = reset_n & (count_q < CAP_C) & (mem_cnt_q < DEPTH_C);
        deq_valid_s = reset_n & ((obuf_cnt_q != 2'd0) | rd_inflight_q);
        enq_fire_s  = enq_valid & enq_ready_s;
        deq_fire_s  = deq_ready & deq_valid_s;

        // Words already on their way to the consumer (buffered or in flight).
        occ_s = {1'b0, obuf_cnt_q} + {2'b00, rd_inflight_q};

        // Registered mem_cnt only: a word written this cycle is never read back
        // in the same cycle, so the two ports never collide on an address.
        rd_issue_s = reset_n & (mem_cnt_q != {CW{1'b0}})
                   & (occ_s < (3'd2 + {2'b00, deq_fire_s}));

        // Empty buffer with a read returning: the macro output is the head.
        bypass_s    = rd_inflight_q & (obuf_cnt_q == 2'd0);
        obuf_pop_s  = deq_fire_s & ~bypass_s;
        obuf_push_s = rd_inflight_q & ~(deq_fire_s & bypass_s);
    end

    // Pointer, occupancy and read-tracking next state.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mem_cnt_d     = mem_cnt_q;
        count_d       = count_q;
        rd_inflight_d = rd_issue_s;

        if (enq_fire_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_issue_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({enq_fire_s, rd_issue_s})
            2'b10:   mem_cnt_d = mem_cnt_q + CNT_ONE_C;
            2'b01:   mem_cnt_d = mem_cnt_q - CNT_ONE_C;
            default: mem_cnt_d = mem_cnt_q;
        endcase

        case ({enq_fire_s, deq_fire_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Output buffer: in-order, head always in obuf0.
    always_comb begin
        obuf0_d    = obuf0_q;
        obuf1_d    = obuf1_q;
        obuf_cnt_d = obuf_cnt_q;

        case ({obuf_push_s, obuf_pop_s})
            2'b10: begin
                if (obuf_cnt_q == 2'd0) begin
                    obuf0_d = mem_R0_data;
                end else begin
                    obuf1_d = mem_R0_data;
                end
                obuf_cnt_d = obuf_cnt_q + 2'd1;
            end
            2'b01: begin
                obuf0_d    = obuf1_q;
                obuf_cnt_d = obuf_cnt_q - 2'd1;
            end
            2'b11: begin
                // Count unchanged; the returning word lands behind whatever remains.
                if (obuf_cnt_q == 2'd1) begin
                    obuf0_d = mem_R0_data;
                end else begin
                    obuf0_d = obuf1_q;
                    obuf1_d = mem_R0_data;
                end
                obuf_cnt_d = obuf_cnt_q;
            end
            default: begin
                obuf_cnt_d = obuf_cnt_q;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            mem_cnt_q     <= {CW{1'b0}};
            rd_inflight_q <= 1'b0;
            obuf_cnt_q    <= 2'd0;
            obuf0_q       <= {WIDTH{1'b0}};
            obuf1_q       <= {WIDTH{1'b0}};
            count_q       <= {CW{1'b0}};
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_cnt_q     <= mem_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            obuf_cnt_q    <= obuf_cnt_d;
            obuf0_q       <= obuf0_d;
            obuf1_q       <= obuf1_d;
            count_q       <= count_d;
        end
    end

    assign enq_ready   = enq_ready_s;
    assign deq_valid   = deq_valid_s;
    assign deq_data    = bypass_s ? mem_R0_data : obuf0_q;
    assign count       = count_q;
    assign mem_W0_en   = enq_fire_s;
    assign mem_W0_addr = wr_ptr_q;
    assign mem_W0_data = enq_data;
    assign mem_R0_en   = rd_issue_s;
    assign mem_R0_addr = rd_ptr_q;

endmodule
